// File: rtl/arc4_pkg.sv
// ARC4 shared types and constants.
// State-array geometry, FSM encodings and 7-seg decode.
package arc4_pkg;

  localparam int S_DEPTH = 256;
  localparam int S_WIDTH = 8;
  localparam int S_AW    = $clog2(S_DEPTH);

  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    RESET_IDLE,
    START,
    WAIT_INIT,
    DONE
  } top_state_e;

  typedef enum logic {
    IDLE,
    WRITE
  } init_state_e;

  // Active-low segments, bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/task1_top_s_init.sv
// ARC4 state-array fill engine.
// Writes S[i] = i for every entry, one per cycle.
module s_init
  import arc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [S_AW-1:0]   addr,
  output logic [S_WIDTH-1:0] wrdata,
  output logic              wren
);

  init_state_e      state_q, state_d;
  logic [S_AW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy     = 1'b0;
    wren    = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        wren = 1'b1;
        // Saturate on the last entry so address 0 is never rewritten.
        if (cnt_q == S_AW'(S_DEPTH - 1)) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr   = cnt_q;
  assign wrdata = S_WIDTH'(cnt_q);

endmodule

// File: rtl/task1_top.sv
// DE1-SoC top for ARC4 stage 1: fills S, shows completion
// on LEDR and a debug byte of S on HEX1:HEX0.
module task1_top
  import arc4_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  logic rst_n;
  assign rst_n = KEY[3];

  top_state_e state_q, state_d;

  logic               s_en, s_rdy, s_wren;
  logic [S_AW-1:0]    s_addr;
  logic [S_WIDTH-1:0] s_wrdata;
  logic [S_WIDTH-1:0] rd_q;
  logic [S_WIDTH-1:0] s_mem [S_DEPTH];

  logic unused_ok;
  assign unused_ok = ^{KEY[2:0], SW[9:8]};

  s_init u_init (
    .clk    (CLOCK_50),
    .rst_n  (rst_n),
    .en     (s_en),
    .rdy    (s_rdy),
    .addr   (s_addr),
    .wrdata (s_wrdata),
    .wren   (s_wren)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_en    = 1'b0;
    case (state_q)
      RESET_IDLE: state_d = START;
      START: begin
        s_en    = 1'b1;
        state_d = WAIT_INIT;
      end
      WAIT_INIT: if (s_rdy) state_d = DONE;
      DONE:      state_d = DONE;
      default:   state_d = RESET_IDLE;
    endcase
  end

  // No reset on the array or its read register: block RAM.
  always_ff @(posedge CLOCK_50) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    rd_q <= s_mem[SW[S_AW-1:0]];
  end

  logic done, busy;
  assign done = (state_q == DONE);
  assign busy = (state_q == WAIT_INIT);

  assign HEX0 = done ? seg7(rd_q[3:0]) : HEX_BLANK;
  assign HEX1 = done ? seg7(rd_q[7:4]) : HEX_BLANK;
  assign HEX2 = HEX_BLANK;
  assign HEX3 = HEX_BLANK;
  assign HEX4 = HEX_BLANK;
  assign HEX5 = HEX_BLANK;
  assign LEDR = {8'b0, busy, done};

endmodule

// File: tb/tb_task1_top.sv
// Directed bench for task1_top: fill timing, write order,
// debug read path and reset behaviour.
module tb_task1_top;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int n_chk = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int exp_addr = 0;
  int addr_err = 0;

  localparam logic [6:0] BLK = 7'h7F;
  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] SF  = 7'b0001110;

  task1_top dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .LEDR     (LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Write monitor; a reset restarts the expected order.
  always @(negedge CLOCK_50) begin
    if (!KEY[3]) begin
      wr_cnt   = 0;
      exp_addr = 0;
    end else if (dut.s_wren) begin
      if (dut.s_addr != exp_addr[7:0] ||
          dut.s_wrdata != exp_addr[7:0])
        addr_err++;
      exp_addr++;
      wr_cnt++;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mem_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut.s_mem[i] !== 8'(i)) bad++;
    check(tag, bad, 0);
  endtask

  // Counts edges from release until LEDR[0]; also profiles busy/hex.
  task automatic run_fill(output int lat, output int busy,
                          output int bad);
    lat  = 0;
    busy = 0;
    bad  = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge CLOCK_50);
      #1;
      if (LEDR[1]) busy++;
      if (!LEDR[0] && {HEX0, HEX1, HEX2, HEX3, HEX4, HEX5}
          !== {6{BLK}})
        bad++;
      if (LEDR[0]) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat, busy, bad;

  initial begin
    KEY = 4'b0111;
    SW  = 10'h000;
    #1;
    check("rst_ledr", LEDR, 0);
    check("rst_hex0", HEX0, BLK);
    check("rst_hex1", HEX1, BLK);
    check("rst_hex5", HEX5, BLK);
    @(negedge CLOCK_50);
    KEY[3] = 1'b1;

    run_fill(lat, busy, bad);
    check("done_lat_ok", (lat >= 258 && lat <= 260), 1);
    check("done_lat", lat, 259);
    check("busy_cycles", busy, 257);
    check("fill_hex_blank", bad, 0);
    check("wr_count", wr_cnt, 256);
    check("wr_order", addr_err, 0);
    mem_check("mem_fill");

    repeat (50) @(posedge CLOCK_50);
    #1;
    check("done_hold", LEDR, 10'h001);
    check("no_rewrite", wr_cnt, 256);

    check("rd00_hex1", HEX1, S0);
    check("rd00_hex0", HEX0, S0);
    SW = 10'h07F;
    @(negedge CLOCK_50);
    check("rd7f_lag", HEX0, S0);
    @(posedge CLOCK_50);
    #1;
    check("rd7f_hex1", HEX1, S7);
    check("rd7f_hex0", HEX0, SF);
    SW = 10'h0FF;
    @(negedge CLOCK_50);
    check("rdff_lag", HEX1, S7);
    @(posedge CLOCK_50);
    #1;
    check("rdff_hex1", HEX1, SF);
    check("rdff_hex0", HEX0, SF);
    SW = 10'h312;
    @(posedge CLOCK_50);
    #1;
    check("rd12_hex1", HEX1, S1);
    check("rd12_hex0", HEX0, S2);

    @(negedge CLOCK_50);
    KEY[3] = 1'b0;
    #1;
    check("mid_rst_ledr", LEDR, 0);
    check("mid_rst_hex0", HEX0, BLK);
    @(negedge CLOCK_50);
    KEY[3] = 1'b1;
    repeat (100) @(posedge CLOCK_50);
    #1;
    check("restart_done", LEDR[0], 0);
    check("restart_busy", LEDR[1], 1);
    check("restart_wr", wr_cnt, 98);
    check("restart_order", addr_err, 0);
    mem_check("mem_restart");

    @(posedge CLOCK_50);
    #1;
    check("wren_pre", dut.s_wren, 1);
    #1;
    KEY[3] = 1'b0;
    #1;
    check("async_wren", dut.s_wren, 0);
    check("async_ledr", LEDR, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    KEY[3] = 1'b1;
    run_fill(lat, busy, bad);
    check("async_lat_ok", (lat >= 1 && lat <= 260), 1);
    check("async_wr", wr_cnt, 256);
    check("async_order", addr_err, 0);
    mem_check("mem_async");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/task1_top.md
Name: task1_top

Overview:
- DE1-SoC board-level top for ARC4 stage 1 (state-array initialisation).
- After reset release, fills an internal 256x8 RAM `S` with `S[i] = i` for `i` = 0..255.
- Reports completion on `LEDR[0]`.
- Exposes a debug read port: `SW[7:0]` selects an address, and its byte appears on `HEX1:HEX0`.

Parameters:
- None. Board top; depth 256 and width 8 are fixed constants in the package.

Ports:
- `CLOCK_50` input 1: system clock; all logic on its rising edge.
- `KEY` input 4: push-buttons. `KEY[3]` = reset_n, asynchronous, active-low. `KEY[2:0]` unused.
- `SW` input 10: `SW[7:0]` = debug read address. `SW[9:8]` unused.
- `HEX0` output 7: low nibble of debug byte, 7-seg active-low, bit6 = segment g.
- `HEX1` output 7: high nibble of debug byte, same encoding.
- `HEX2`..`HEX5` output 7 each: blank (7'h7F).
- `LEDR` output 10: `LEDR[0]` = init done, `LEDR[1]` = init busy, `LEDR[9:2]` = 0.

Behaviour:
- One clock `CLOCK_50`; reset is asynchronous, active-low on `KEY[3]`.
- Top FSM states: RESET_IDLE, START, WAIT_INIT, DONE.

Reset asserted (`KEY[3]`=0), immediately:
- FSM goes to RESET_IDLE and the init counter is cleared.
- `LEDR` = 0; `HEX2`..`HEX5` = 7'h7F.
- `HEX1`/`HEX0` = 7'h7F (blank) until DONE.
- RAM contents are not cleared.

Sequencing after reset release:
- First rising edge after release: RESET_IDLE -> START. `en` to `s_init` pulses high for exactly 1 cycle.
- `s_init` handshake:
  - `rdy` is high when idle.
  - `en` is sampled only while `rdy`=1; `rdy` drops the cycle after `en` is accepted.
  - `s_init` writes `addr=i`, `wrdata=i`, `wren=1` on 256 consecutive cycles, i = 0..255.
  - `rdy` returns high the cycle after the write of 255.
- WAIT_INIT -> DONE on `rdy`=1. `LEDR[1]`=1 during WAIT_INIT; `LEDR[0]`=1 in DONE.
- Timing: write of address `k` at edge k+2 after release; `LEDR[0]` rises at edge 259 ±1. The requirement is ≤ 260 cycles.
- DONE is terminal until the next reset. No re-trigger from `KEY[2:0]` or `SW`.

Write port:
- One write per cycle, 8-bit address counter.
- No wrap: the counter stops at 255 and never writes address 0 twice in one run.

Debug read port:
- Synchronous; `HEX1:HEX0` show `S[SW[7:0]]` 1 cycle after `SW` changes.
- Valid only in DONE; blank (7'h7F) otherwise.

Reset mid-operation:
- Async abort. Partially written RAM is left as is.
- On release the full sequence restarts from address 0, and `LEDR[0]` stays 0 until the new run completes.

7-seg encoding:
- Standard hex, active-low: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 7=7'b1111000, F=7'b0001110.

RAM:
- 256x8, one write port (init) and one read port (debug). Inferable as block RAM, registered read.

Decomposition:
- Package `arc4_pkg`:
  - `S_DEPTH` = 256, `S_WIDTH` = 8.
  - top FSM state enum.
  - 7-seg lookup function.
  - `HEX_BLANK` = 7'h7F.
- Sub-module `s_init`:
  - ports: `clk`, `rst_n`, `en`, `rdy`, `addr[7:0]`, `wrdata[7:0]`, `wren`.
  - states IDLE/WRITE.
- Top holds the RAM array, FSM, debug read path and display decode.

Test Plan:
- Reset sequence:
  - Stimulus: `KEY[3]` low 1 cycle, release, run 650 cycles.
  - Required: `LEDR[0]`=1 by cycle 260; `LEDR[1]`=1 only during fill.
  - Required: `S[i]`=i for all 256 entries (backdoor check); exactly 256 `wren` pulses, addresses 0..255 in order.
- Debug read after DONE:
  - `SW[7:0]`=8'h00 -> `HEX1`=7'b1000000, `HEX0`=7'b1000000.
  - `SW[7:0]`=8'h7F -> `HEX1`=7'b1111000, `HEX0`=7'b0001110.
  - `SW[7:0]`=8'hFF -> both `HEX` show F; each update 1 cycle after the `SW` change.
- Before DONE:
  - During fill, `HEX0`..`HEX5` all 7'h7F and `LEDR[0]`=0.
- Reset mid-operation:
  - Stimulus: after DONE, pulse `KEY[3]` low 1 cycle, release, run 100 cycles.
  - Required: `LEDR[0]`=0, `LEDR[1]`=1; writes restart at address 0 with ~98 writes issued.
  - Required: `S` still reads i everywhere.
- Asynchronous reset:
  - Stimulus: assert `KEY[3]` mid-cycle during fill.
  - Required: `wren`/`LEDR` drop before the next clock edge; after release, `LEDR[0]` again rises within 260 cycles.
